// File: rtl/uart_tx_fifo.sv
// Byte FIFO with a launch sequencer that feeds a UART transmitter one byte per frame.
// Overflow is reported through a sticky flag; writers are never stalled.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [7:0]          wr_data,
    input  logic                clr_overflow,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] count,
    output logic                overflow,
    output logic                busy,
    output logic                uart_transmit,
    output logic [7:0]          uart_tx_byte,
    input  logic                uart_is_transmitting
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  wr_accept;
    logic                  pop;

    // Handshake: a write is taken on any edge with wr_en && !full (no ready back to the
    // writer); towards the UART, uart_transmit stays high until uart_is_transmitting
    // acknowledges it, and the next byte is not offered until that line falls again.
    assign full          = (count == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty         = (count == '0);
    assign wr_accept     = wr_en && !full;
    assign pop           = (state == S_IDLE) && !empty && !uart_is_transmitting;
    assign uart_transmit = (state == S_LAUNCH);
    assign busy          = !empty || (state != S_IDLE);

    // Storage array is left unreset; only the pointers define valid contents.
    always_ff @(posedge clk) begin
        if (!rst && wr_accept) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow     <= 1'b0;
            uart_tx_byte <= 8'h00;
            state        <= S_IDLE;
        end else begin
            state <= state_next;
            if (wr_accept) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (pop) begin
                uart_tx_byte <= mem[rd_ptr];
                rd_ptr       <= rd_ptr + DEPTH_LOG2'(1);
            end
            case ({wr_accept, pop})
                2'b10:   count <= count + (DEPTH_LOG2 + 1)'(1);
                2'b01:   count <= count - (DEPTH_LOG2 + 1)'(1);
                default: count <= count;
            endcase
            // A dropped write in the same cycle as a clear leaves the flag set.
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (pop) begin
                    state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (uart_is_transmitting) begin
                    state_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!uart_is_transmitting) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo: a queue-based reference model plus a small
// serialising UART model whose received bytes are scored against the expected order.
module tb_uart_tx_fifo;

    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int BIT_CLKS   = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                wr_en;
    logic [7:0]          wr_data;
    logic                clr_overflow;
    logic                full;
    logic                empty;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;
    logic                busy;
    logic                uart_transmit;
    logic [7:0]          uart_tx_byte;
    logic                uart_is_transmitting;

    int checks   = 0;
    int failures = 0;

    uart_tx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .wr_en                (wr_en),
        .wr_data              (wr_data),
        .clr_overflow         (clr_overflow),
        .full                 (full),
        .empty                (empty),
        .count                (count),
        .overflow             (overflow),
        .busy                 (busy),
        .uart_transmit        (uart_transmit),
        .uart_tx_byte         (uart_tx_byte),
        .uart_is_transmitting (uart_is_transmitting)
    );

    always #5 clk = ~clk;

    // Reference model: contents as a queue, sequencer as two phase flags.
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    logic       m_ovf     = 1'b0;
    logic [7:0] m_byte    = 8'h00;
    logic       m_launch  = 1'b0;
    logic       m_waiting = 1'b0;

    // UART model with a hold override that forces is_transmitting high.
    logic       hold_tx = 1'b0;
    logic       u_busy  = 1'b0;
    logic [9:0] u_shreg = 10'h3ff;
    logic [9:0] u_rx    = 10'h000;
    int         u_bit   = 0;
    int         u_sub   = 0;
    int         u_frames = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_is_tx();
        uart_is_transmitting = u_busy || hold_tx;
    endtask

    task automatic set_hold(input logic v);
        hold_tx = v;
        drive_is_tx();
    endtask

    task automatic uart_edge(input logic p_rst, input logic p_tx, input logic [7:0] p_byte);
        logic [7:0] want;
        if (p_rst) begin
            u_busy  = 1'b0;
            u_shreg = 10'h3ff;
        end else if (u_busy) begin
            if (u_sub == 0) u_rx[u_bit] = u_shreg[0];
            if (u_sub == BIT_CLKS - 1) begin
                u_sub   = 0;
                u_shreg = {1'b1, u_shreg[9:1]};
                if (u_bit == 9) begin
                    u_busy = 1'b0;
                    u_frames++;
                    check("uart_stop_bit", 32'(u_rx[9]), 32'd1);
                    if (exp_q.size() == 0) begin
                        check("uart_spurious_frame", 32'(u_rx[8:1]), 32'h1ff);
                    end else begin
                        want = exp_q.pop_front();
                        check("uart_rx_byte", 32'(u_rx[8:1]), 32'(want));
                    end
                end else begin
                    u_bit++;
                end
            end else begin
                u_sub++;
            end
        end else if (p_tx) begin
            u_busy  = 1'b1;
            u_shreg = {1'b1, p_byte, 1'b0};
            u_bit   = 0;
            u_sub   = 0;
        end
    endtask

    task automatic model_edge(input logic p_rst, input logic p_wr, input logic [7:0] p_data,
                              input logic p_clr, input logic p_istx);
        logic acc;
        logic popped;
        if (p_rst) begin
            fifo_q.delete();
            exp_q.delete();
            m_ovf = 1'b0; m_byte = 8'h00; m_launch = 1'b0; m_waiting = 1'b0;
            return;
        end
        acc    = p_wr && (fifo_q.size() < DEPTH);
        popped = !m_launch && !m_waiting && (fifo_q.size() > 0) && !p_istx;
        if (p_wr && !acc) m_ovf = 1'b1;
        else if (p_clr)   m_ovf = 1'b0;
        if (m_launch && p_istx) begin
            m_launch = 1'b0; m_waiting = 1'b1;
        end else if (m_waiting && !p_istx) begin
            m_waiting = 1'b0;
        end
        if (popped) begin
            m_byte = fifo_q.pop_front();
            exp_q.push_back(m_byte);
            m_launch = 1'b1;
        end
        if (acc) fifo_q.push_back(p_data);
    endtask

    task automatic compare_all();
        check("count",         32'(count),         32'(fifo_q.size()));
        check("full",          32'(full),          32'(fifo_q.size() == DEPTH));
        check("empty",         32'(empty),         32'(fifo_q.size() == 0));
        check("overflow",      32'(overflow),      32'(m_ovf));
        check("busy",          32'(busy),          32'((fifo_q.size() > 0) || m_launch || m_waiting));
        check("uart_transmit", 32'(uart_transmit), 32'(m_launch));
        check("uart_tx_byte",  32'(uart_tx_byte),  32'(m_byte));
    endtask

    task automatic step();
        logic       p_rst, p_wr, p_clr, p_istx, p_tx;
        logic [7:0] p_data, p_byte;
        p_rst = rst; p_wr = wr_en; p_data = wr_data; p_clr = clr_overflow;
        p_istx = uart_is_transmitting; p_tx = uart_transmit; p_byte = uart_tx_byte;
        @(posedge clk);
        #1;
        model_edge(p_rst, p_wr, p_data, p_clr, p_istx);
        uart_edge(p_rst, p_tx, p_byte);
        drive_is_tx();
        compare_all();
    endtask

    task automatic cyc(input logic w, input logic [7:0] d, input logic c);
        wr_en = w; wr_data = d; clr_overflow = c;
        step();
        wr_en = 1'b0; clr_overflow = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((fifo_q.size() > 0 || m_launch || m_waiting || u_busy || exp_q.size() > 0)
               && n < budget) begin
            idle(1);
            n++;
        end
        check("drain_timeout", 32'(n < budget), 32'd1);
    endtask

    initial begin
        int sent;
        int iters;
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clr_overflow = 1'b0;
        uart_is_transmitting = 1'b0;

        do_reset();
        check("rst_count",    32'(count), 32'd0);
        check("rst_empty",    32'(empty), 32'd1);
        check("rst_transmit", 32'(uart_transmit), 32'd0);
        check("rst_tx_byte",  32'(uart_tx_byte), 32'h00);

        // Single byte: transmit is high for exactly two cycles starting one after the write.
        cyc(1'b1, 8'hA5, 1'b0);
        check("a5_count_after_write", 32'(count), 32'd1);
        check("a5_tx_low_after_write", 32'(uart_transmit), 32'd0);
        idle(1);
        check("a5_tx_high_1", 32'(uart_transmit), 32'd1);
        check("a5_tx_byte", 32'(uart_tx_byte), 32'hA5);
        check("a5_count_zero", 32'(count), 32'd0);
        idle(1);
        check("a5_tx_high_2", 32'(uart_transmit), 32'd1);
        idle(1);
        check("a5_tx_low", 32'(uart_transmit), 32'd0);
        drain(200);
        check("a5_frames", 32'(u_frames), 32'd1);

        // Burst of 16 with the line held, then a 17th byte that must be dropped.
        set_hold(1'b1);
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(i), 1'b0);
        cyc(1'b1, 8'hFF, 1'b0);
        check("burst_full", 32'(full), 32'd1);
        check("burst_overflow", 32'(overflow), 32'd1);
        set_hold(1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        check("burst_ovf_cleared", 32'(overflow), 32'd0);
        drain(1000);

        // Held line: three bytes stay queued until release.
        set_hold(1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        idle(3);
        check("hold_count3", 32'(count), 32'd3);
        check("hold_no_launch", 32'(uart_transmit), 32'd0);
        set_hold(1'b0);
        drain(500);

        // Write and pop on the same edge at count 5.
        set_hold(1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'h50 + 8'(i), 1'b0);
        set_hold(1'b0);
        cyc(1'b1, 8'h55, 1'b0);
        check("wr_pop_count5", 32'(count), 32'd5);
        drain(1000);

        // Write while full plus pop, with a clear in the same cycle: the set wins.
        set_hold(1'b1);
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'h80 + 8'(i), 1'b0);
        set_hold(1'b0);
        cyc(1'b1, 8'hEE, 1'b1);
        check("full_pop_count", 32'(count), 32'(DEPTH - 1));
        check("full_pop_ovf_set_wins", 32'(overflow), 32'd1);
        drain(1000);
        cyc(1'b0, 8'h00, 1'b1);

        // Reset while launching.
        cyc(1'b1, 8'h3C, 1'b0);
        idle(1);
        check("launch_before_rst", 32'(uart_transmit), 32'd1);
        do_reset();
        check("launch_rst_tx", 32'(uart_transmit), 32'd0);
        check("launch_rst_busy", 32'(busy), 32'd0);
        idle(4);

        // Reset mid-frame with a byte still queued.
        cyc(1'b1, 8'hC3, 1'b0);
        cyc(1'b1, 8'h5A, 1'b0);
        iters = 0;
        while (!u_busy && iters < 20) begin idle(1); iters++; end
        check("midframe_started", 32'(u_busy), 32'd1);
        idle(5);
        do_reset();
        check("midframe_rst_count", 32'(count), 32'd0);
        check("midframe_rst_byte", 32'(uart_tx_byte), 32'h00);
        idle(6);

        // Pointer wrap: 40 random bytes, writer kept below full.
        sent = 0; iters = 0;
        while (sent < 40 && iters < 5000) begin
            if ($urandom_range(0, 3) != 0 && fifo_q.size() < DEPTH - 1) begin
                cyc(1'b1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 7) == 0));
                sent++;
            end else begin
                idle(1);
            end
            iters++;
        end
        check("wrap_all_sent", 32'(sent), 32'd40);
        drain(3000);

        // Free-running random traffic, overflow allowed.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 9) == 0));
        end
        drain(3000);
        check("final_exp_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
